// File: rtl/mux_rr_nto1.sv
// ---------------------------------------------------------------------------
// mux_rr_nto1
//   N-to-1 round-robin multiplexer with a registered valid/ready output stage.
//   Several producers share one consumer. At most one channel is granted per
//   cycle. The granted word is captured into the output register, and a
//   drain and refill can happen in the same cycle, so throughput is one word
//   per clock.
//
//   Optional build macro: MUX_RR_LOCK_EN
//     When defined, a transfer with in_last=0 locks the grant onto that
//     channel until a transfer with in_last=1 completes the packet.
//     When undefined, in_last is ignored and arbitration is per word.
//
// Parameters
//   N   number of input channels (N >= 2)
//   W   data width per channel
//   SW  channel index width, derived as $clog2(N); do not override
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [N]    per-channel valid
//   in_data    [N*W]  packed channel data, channel i in [i*W +: W]
//   in_ready   [N]    per-channel ready, one-hot or zero
//   in_last    [N]    per-channel end-of-packet (lock build only)
//   out_valid         output register holds a word
//   out_data   [W]    registered data
//   out_sel    [SW]   index of the channel that supplied out_data
//   out_ready         consumer ready
// ---------------------------------------------------------------------------
module mux_rr_nto1 #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    in_last,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic          load;
  logic          scan_hit;
  logic [SW-1:0] scan_idx;
  logic          locked;
  logic [SW-1:0] lock_ch;
  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [W-1:0]  gnt_data;
  logic          xfer;
  logic          ptr_adv;
  logic [SW-1:0] ptr_next;

  // The output stage can take a word when it is empty or being drained now.
  assign load = !out_valid | out_ready;

  // Round-robin scan: first valid channel at or after ptr, wrapping modulo N.
  always_comb begin
    int            idx;
    logic [SW-1:0] cand;
    scan_hit = 1'b0;
    scan_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = SW'(idx);
      if (!scan_hit && in_valid[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // While locked the grant is forced to the locked channel, valid or not, so
  // that no other channel can slip a word into the middle of a packet.
  assign gnt_any = locked | scan_hit;
  assign gnt_idx = locked ? lock_ch : scan_idx;
  assign gnt_vld = locked ? in_valid[lock_ch] : scan_hit;
  assign xfer    = gnt_vld & load;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load & gnt_any & (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  assign ptr_next = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;

`ifdef MUX_RR_LOCK_EN
  // state   | meaning
  // --------+-----------------------------------------------------------
  // ST_ARB  | free arbitration, round-robin scan from ptr
  // ST_LOCK | mid-packet, grant held on lock_ch until its in_last beat
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_t;

  lock_state_t   state, state_nxt;
  logic [SW-1:0] lock_ch_q, lock_ch_nxt;
  logic          last_beat;

  assign last_beat = in_last[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      lock_ch_q <= '0;
    end else begin
      state     <= state_nxt;
      lock_ch_q <= lock_ch_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch_q;
    if (xfer) begin
      if (last_beat) begin
        state_nxt = ST_ARB;
      end else begin
        state_nxt   = ST_LOCK;
        lock_ch_nxt = gnt_idx;
      end
    end
  end

  assign locked  = (state == ST_LOCK);
  assign lock_ch = lock_ch_q;
  // Pointer only moves once a packet completes.
  assign ptr_adv = xfer & last_beat;
`else
  logic unused_last;

  assign unused_last = ^in_last;
  assign locked      = 1'b0;
  assign lock_ch     = '0;
  assign ptr_adv     = xfer;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ptr_adv) begin
      ptr <= ptr_next;
    end
  end

  // Refill wins over drain, so a simultaneous drain and refill keeps
  // out_valid high with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
